// File: rtl/pc_sequencer.sv
// Program counter sequencer: owns the PC register, selects pc+1 or a queued jump target,
// and presents each PC to instruction fetch over a valid/ready handshake.
module pc_sequencer #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned RESET_PC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             jump_req,
    input  logic [WIDTH-1:0] jump_addr,
    output logic             jump_ack,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [WIDTH-1:0] pc,
    output logic             mux_sel,
    output logic             busy,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ResetPc = WIDTH'(RESET_PC);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic             pend_valid_q, pend_valid_d;
    logic             fetch_valid_q;
    logic             busy_q;
    logic             wrap_q, wrap_d;
    logic             transfer;

    // State register; fetch_valid and busy are flopped alongside so they track the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            fetch_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= (state_d == StRun);
            busy_q        <= (state_d == StRun);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StRun;
            StRun:    if (halt && transfer) state_d = StHalted;
            StHalted: if (start) state_d = StRun;
            default:  state_d = StIdle;
        endcase
    end

    // Combinational outputs are forced low during reset.
    always_comb begin
        transfer = fetch_valid_q & fetch_ready;
        jump_ack = ~reset & jump_req & ~pend_valid_q & (state_q != StHalted);
        mux_sel  = ~reset & transfer & pend_valid_q;
    end

    always_comb begin
        pc_d         = pc_q;
        pend_addr_d  = pend_addr_q;
        pend_valid_d = pend_valid_q;
        wrap_d       = 1'b0;
        if (transfer) begin
            if (pend_valid_q) begin
                pc_d         = pend_addr_q;
                pend_valid_d = 1'b0;
            end else begin
                pc_d   = pc_q + 1'b1;
                wrap_d = (pc_q == '1);
            end
        end
        // Accept only happens with the entry empty, so it never collides with the consume above.
        if (jump_ack) begin
            pend_addr_d  = jump_addr;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= ResetPc;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
            wrap_q       <= wrap_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign busy        = busy_q;
    assign pc          = pc_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts each cycle's
// outputs, and a separate monitor pops and compares them against the DUT.
module tb_pc_sequencer;

    localparam int W = 6;
    localparam int RESET_PC = 0;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b0, start = 1'b0, halt = 1'b0, jump_req = 1'b0, fetch_ready = 1'b0;
    logic [W-1:0] jump_addr = '0;
    logic         jump_ack, fetch_valid, mux_sel, busy, wrap;
    logic [W-1:0] pc;

    pc_sequencer #(.WIDTH(W), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt        (halt),
        .jump_req    (jump_req),
        .jump_addr   (jump_addr),
        .jump_ack    (jump_ack),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .pc          (pc),
        .mux_sel     (mux_sel),
        .busy        (busy),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit known;
        bit fv;
        bit bsy;
        bit wrp;
        bit ack;
        bit mux;
        int pcv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: abstract run/halt flags, integer pc, and a one-deep queue of jumps.
    bit m_known = 0;
    bit m_running = 0;
    bit m_halted = 0;
    bit m_wrap = 0;
    int m_pc = 0;
    int m_pend[$];

    task automatic step(input bit r, input bit s, input bit h, input bit jr, input int ja,
                        input bit rdy, output bit ack);
        exp_t e;
        bit   xfer;
        bit   nwrap;
        @(negedge clk);
        reset = r; start = s; halt = h; jump_req = jr; jump_addr = W'(ja); fetch_ready = rdy;
        e.known = m_known;
        e.fv    = m_running;
        e.bsy   = m_running;
        e.wrp   = m_wrap;
        e.pcv   = m_pc;
        if (r) begin
            ack = 0; e.ack = 0; e.mux = 0;
            m_running = 0; m_halted = 0; m_pc = RESET_PC; m_pend.delete(); m_wrap = 0;
            m_known = 1;
        end else begin
            xfer  = m_running && rdy;
            ack   = jr && m_pend.size() == 0 && !m_halted;
            e.ack = ack;
            e.mux = xfer && m_pend.size() != 0;
            nwrap = 0;
            if (xfer) begin
                if (m_pend.size() != 0) m_pc = m_pend.pop_front();
                else begin
                    nwrap = (m_pc == MOD - 1);
                    m_pc = (m_pc + 1) % MOD;
                end
            end
            if (ack) m_pend.push_back(ja);
            if (m_running && xfer && h) begin
                m_running = 0; m_halted = 1;
            end else if (!m_running && s) begin
                m_running = 1; m_halted = 0;
            end
            m_wrap = nwrap;
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples 2 time units after the stimulus edge, well before the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("jump_ack", int'(jump_ack), int'(e.ack));
                check("mux_sel", int'(mux_sel), int'(e.mux));
                if (e.known) begin
                    check("fetch_valid", int'(fetch_valid), int'(e.fv));
                    check("busy", int'(busy), int'(e.bsy));
                    check("wrap", int'(wrap), int'(e.wrp));
                    check("pc", int'(pc), e.pcv);
                end
            end
        end
    end

    initial begin
        bit ack;
        bit hold_req;
        int hold_addr;
        // Reset, start, then jump near the top to exercise wrap and a jump to 0.
        step(1, 0, 0, 0, 0, 0, ack);
        step(1, 0, 0, 0, 0, 0, ack);
        step(0, 1, 0, 0, 0, 1, ack);
        step(0, 0, 0, 1, 62, 1, ack);
        step(0, 0, 0, 0, 0, 1, ack);
        step(0, 0, 0, 0, 0, 1, ack);
        step(0, 0, 0, 1, 0, 1, ack);
        step(0, 0, 0, 0, 0, 1, ack);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, ack);
        // Stall with halt held, then release: halt takes effect on the transfer.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, ack);
        step(0, 0, 1, 0, 0, 1, ack);
        step(0, 0, 0, 1, 20, 1, ack);
        step(0, 0, 0, 1, 20, 1, ack);
        step(0, 1, 0, 1, 20, 1, ack);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, ack);
        // Pending jump during a stall, discarded by reset.
        step(0, 0, 0, 1, 33, 0, ack);
        step(0, 0, 0, 0, 0, 0, ack);
        step(1, 0, 0, 0, 0, 0, ack);
        step(0, 1, 0, 0, 0, 1, ack);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, ack);

        // Randomized phase; an unacknowledged request is held with its address.
        hold_req = 0;
        hold_addr = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, s, h, jr, rdy;
            int ja;
            r   = ($urandom_range(99) < 2);
            s   = ($urandom_range(99) < 25);
            h   = ($urandom_range(99) < 8);
            rdy = ($urandom_range(99) < 75);
            if (hold_req) begin
                jr = 1; ja = hold_addr;
            end else begin
                jr = ($urandom_range(99) < 30);
                ja = (($urandom_range(99) < 15) ? 0 : int'($urandom_range(MOD - 1)));
            end
            step(r, s, h, jr, ja, rdy, ack);
            hold_req  = jr && !ack && !r;
            hold_addr = ja;
        end

        @(negedge clk);
        #4;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Controller for the 6-bit program counter datapath. It owns the PC register, drives the select line of the PC next-address 2:1 mux, and chooses between two next-address sources: sequential (d0 = pc+1) and jump target (d1).
- Queues one jump request from the control side.
- Presents each PC to instruction fetch over a valid/ready handshake.
- Sequences run/halt of the counter.

Parameters:
WIDTH, 6, PC and jump address width in bits
RESET_PC, 0, PC value loaded on reset (must fit in WIDTH bits)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  level; leaves IDLE/HALTED and begins fetching
halt  in  1  level; stop request, honoured only on a fetch transfer
jump_req  in  1  jump request; held by requester until jump_ack
jump_addr  in  WIDTH  jump target, sampled when jump_ack=1
jump_ack  out  1  combinational; request accepted this cycle
fetch_valid  out  1  pc is valid for fetch
fetch_ready  in  1  fetch accepts pc; transfer = fetch_valid & fetch_ready
pc  out  WIDTH  current program counter (registered)
mux_sel  out  1  combinational; 1 = next pc taken from jump target (d1), 0 = pc+1 (d0)
busy  out  1  registered; 1 while in RUN
wrap  out  1  registered one-cycle pulse; sequential increment wrapped all-ones -> 0

Behaviour:
- Reset (synchronous; overrides all other inputs in that cycle): state=IDLE, pc=RESET_PC, pend_valid=0, fetch_valid=0, busy=0, wrap=0. Combinational outputs jump_ack and mux_sel evaluate to 0 in the reset cycle.
- FSM states: IDLE, RUN, HALTED.
  - IDLE/HALTED -> RUN when start=1.
  - RUN -> HALTED when halt=1 and a transfer occurs in that cycle.
  - No other transitions.
- fetch_valid = (state==RUN), registered with the state.
- Handshake: while fetch_valid=1 and fetch_ready=0, pc holds stable and halt is not honoured.
- PC update: occurs only on a transfer cycle; pc is unchanged in all other cycles.
  - pend_valid=1: pc <= pend_addr, mux_sel=1, pend_valid <= 0.
  - pend_valid=0: pc <= (pc+1) mod 2^WIDTH, mux_sel=0.
- wrap: 1 in the cycle after a sequential update from 2^WIDTH-1 to 0. A jump to 0 never raises wrap.
- Pending jump register (one entry: pend_valid, pend_addr):
  - jump_ack = jump_req & ~pend_valid & (state != HALTED).
  - When jump_ack=1: pend_addr <= jump_addr, pend_valid <= 1.
  - Requests are accepted in IDLE and RUN.
- Jump latency: a jump accepted in cycle N is applied at the first transfer in a cycle >= N+1.
- Simultaneous events:
  - Accept and transfer in the same cycle with pend empty: the transfer uses pc+1; the new jump waits for the next transfer.
  - Pending jump consumed in cycle N: pend_valid=1 in that cycle, so no new accept. A new request can be accepted from cycle N+1.
  - halt and jump applied on the same transfer: pc loads the target, then HALTED. Resuming with start fetches the target.
- HALTED preserves pc and any pending jump; jump_req is stalled (ack=0) until RUN.
- Reset mid-operation (RUN with a pending jump, fetch stalled): the next cycle is IDLE, pc=RESET_PC, the pending jump is discarded, fetch_valid=0.
- start and halt both 1 in RUN: halt wins on a transfer cycle; start has no effect in RUN.

Test Plan:
1. Reset, then start=1 for 1 cycle, fetch_ready=1 constant -> fetch_valid=1 from cycle 2; pc sequence 0,1,2,3...; mux_sel=0; busy=1.
2. Run from pc=62 with ready=1 -> pc 62,63,0; wrap=1 for exactly one cycle after pc becomes 0. Then jump_addr=0 applied -> wrap stays 0.
3. In RUN at pc=5, jump_req=1, jump_addr=40:
   - jump_ack=1 that cycle; the same-cycle transfer gives pc=6.
   - The next transfer gives pc=40 with mux_sel=1, then 41.
   - A second jump_req (addr 10) held during the pending cycle gets ack=0 until pend clears, then is applied later.
4. fetch_ready=0 for 4 cycles at pc=9 with halt=1 -> pc stays 9, state stays RUN. When ready=1, pc becomes 10 and the state goes HALTED; fetch_valid=0; start resumes at 10.
5. HALTED with jump_req=1 -> jump_ack=0 until start; after start, ack=1 and the jump is applied at the following transfer.
6. RUN with a pending jump (addr 33) and fetch_ready=0, assert reset for 1 cycle -> pc=RESET_PC, fetch_valid=0, pend cleared. After start, the sequence runs 0,1,... with no jump to 33.
